pool_unit: RTL and testbench

POOL_UNIT -- requirements
Module: pool_unit

---
 rtl/pool_if.sv | 26 ++
 rtl/pool_unit.sv | 146 ++++++++++++++
 tb/tb_pool_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pool_if.sv
// Pooling unit bus: per-lane sample strobes/data, mode controls and per-lane results.
interface pool_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 2
);
  logic                      pass;
  logic                      clear;
  logic                      mode;
  logic [LANES-1:0]          in_valid;
  logic [LANES*DATA_W-1:0]   in_data;
  logic [LANES-1:0]          out_valid;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [LANES-1:0]          busy;

  // Producer/consumer side (drives samples, observes results).
  modport master (
    output pass, clear, mode, in_valid, in_data,
    input  out_valid, out_data, busy
  );

  // Pooling unit side.
  modport slave (
    input  pass, clear, mode, in_valid, in_data,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/pool_unit.sv
// Multi-lane windowed max/average pooling unit.
// Each lane collects WIN samples and emits one result strobe the cycle after the window closes.
// Optional feature macro: POOL_AVG_EN adds the average datapath (mode = 1); without it every lane
// max-pools and mode is ignored.
module pool_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WIN    = 4,
  parameter int unsigned LANES  = 2,
  parameter bit          SIGNED = 1'b0
) (
  input logic   clk,
  input logic   reset,
  pool_if.slave bus
);
  localparam int unsigned LOG_W = $clog2(WIN);
`ifdef POOL_AVG_EN
  // Room for the full window sum so averaging never overflows.
  localparam int unsigned ACC_W = DATA_W + LOG_W;
`else
  localparam int unsigned ACC_W = DATA_W;
`endif

  logic [LOG_W-1:0]        cnt_q   [LANES];
  logic [LOG_W-1:0]        cnt_d   [LANES];
  logic [ACC_W-1:0]        acc_q   [LANES];
  logic [ACC_W-1:0]        acc_d   [LANES];
  logic [ACC_W-1:0]        samp_x  [LANES];
  logic [ACC_W-1:0]        max_v   [LANES];
  logic [LANES-1:0]        greater;
  logic [LANES-1:0]        out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
`ifdef POOL_AVG_EN
  logic [LANES-1:0]        mode_q, mode_d;
  logic [ACC_W-1:0]        sum_v   [LANES];
  logic [ACC_W-1:0]        avg_s   [LANES];
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  // Widen a sample to accumulator width, sign-extending for two's-complement lanes.
  function automatic logic [ACC_W-1:0] extend(input logic [DATA_W-1:0] s);
`ifdef POOL_AVG_EN
    if (SIGNED) return {{LOG_W{s[DATA_W-1]}}, s};
    else        return {{LOG_W{1'b0}}, s};
`else
    return s;
`endif
  endfunction

  // State register: per-lane counters/accumulators/latched mode plus the result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) begin
        cnt_q[k] <= '0;
        acc_q[k] <= '0;
      end
`ifdef POOL_AVG_EN
      mode_q      <= '0;
`endif
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        cnt_q[k] <= cnt_d[k];
        acc_q[k] <= acc_d[k];
      end
`ifdef POOL_AVG_EN
      mode_q      <= mode_d;
`endif
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next state: window accumulation per lane; bypass and clear both return lanes to idle.
  always_comb begin
    out_valid_d = '0;
    out_data_d  = out_data_q;
`ifdef POOL_AVG_EN
    mode_d      = mode_q;
`endif
    for (int k = 0; k < LANES; k++) begin
      samp_x[k]  = extend(bus.in_data[k*DATA_W +: DATA_W]);
      // Ties keep the accumulator, so only a strictly greater sample replaces it.
      if (SIGNED) begin
        greater[k] = $signed(bus.in_data[k*DATA_W +: DATA_W]) > $signed(acc_q[k][DATA_W-1:0]);
      end else begin
        greater[k] = bus.in_data[k*DATA_W +: DATA_W] > acc_q[k][DATA_W-1:0];
      end
      max_v[k] = greater[k] ? samp_x[k] : acc_q[k];
      cnt_d[k] = cnt_q[k];
      acc_d[k] = acc_q[k];
`ifdef POOL_AVG_EN
      sum_v[k] = acc_q[k] + samp_x[k];
      if (SIGNED) avg_s[k] = $signed(sum_v[k]) >>> LOG_W;
      else        avg_s[k] = sum_v[k] >> LOG_W;
`endif

      if (bus.pass) begin
        cnt_d[k] = '0;
      end else if (bus.clear) begin
        cnt_d[k] = '0;
      end else if (bus.in_valid[k]) begin
        if (cnt_q[k] == '0) begin
          acc_d[k] = samp_x[k];
          cnt_d[k] = LOG_W'(1);
`ifdef POOL_AVG_EN
          mode_d[k] = bus.mode;
`endif
        end else begin
`ifdef POOL_AVG_EN
          acc_d[k] = mode_q[k] ? sum_v[k] : max_v[k];
`else
          acc_d[k] = max_v[k];
`endif
          if (cnt_q[k] == LOG_W'(WIN - 1)) begin
            cnt_d[k]       = '0;
            out_valid_d[k] = 1'b1;
`ifdef POOL_AVG_EN
            out_data_d[k*DATA_W +: DATA_W] = mode_q[k] ? avg_s[k][DATA_W-1:0]
                                                       : max_v[k][DATA_W-1:0];
`else
            out_data_d[k*DATA_W +: DATA_W] = max_v[k][DATA_W-1:0];
`endif
          end else begin
            cnt_d[k] = cnt_q[k] + LOG_W'(1);
          end
        end
      end
    end
    if (bus.pass) begin
      out_valid_d = bus.in_valid;
      out_data_d  = bus.in_data;
    end
  end

  // Outputs: registered results and per-lane partial-window flag.
  always_comb begin
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    for (int k = 0; k < LANES; k++) begin
      bus.busy[k] = (cnt_q[k] != '0);
    end
  end
endmodule

// File: tb/tb_pool_unit.sv
// Self-checking bench for pool_unit: directed vector table, corner sequences, random vs model.
// One unsigned and one signed instance receive identical stimulus.
module tb_pool_unit;
  localparam int unsigned DW    = 16;
  localparam int unsigned WIN   = 4;
  localparam int unsigned LANES = 2;
  localparam int unsigned LOGW  = 2;
`ifdef POOL_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool_if #(.DATA_W(DW), .LANES(LANES)) if_u ();
  pool_if #(.DATA_W(DW), .LANES(LANES)) if_s ();

  pool_unit #(.DATA_W(DW), .WIN(WIN), .LANES(LANES), .SIGNED(1'b0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_u)
  );
  pool_unit #(.DATA_W(DW), .WIN(WIN), .LANES(LANES), .SIGNED(1'b1)) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per lane a list of collected samples and the mode latched at window start.
  int               m_cnt  [2][LANES];
  longint           m_smp  [2][LANES][WIN];
  bit               m_mode [2][LANES];
  logic [LANES-1:0] e_ov   [2];
  logic [DW-1:0]    e_od   [2][LANES];

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint to_val(input logic [DW-1:0] x, input int s);
    if (s != 0 && x[DW-1]) return longint'(x) - (longint'(1) << DW);
    return longint'(x);
  endfunction

  task automatic drive(input bit r, input bit p, input bit c, input bit md,
                       input logic [1:0] iv, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    reset       = r;
    if_u.pass   = p;  if_s.pass   = p;
    if_u.clear  = c;  if_s.clear  = c;
    if_u.mode   = md; if_s.mode   = md;
    if_u.in_valid = iv; if_s.in_valid = iv;
    if_u.in_data  = {d1, d0}; if_s.in_data = {d1, d0};
  endtask

  // Apply the pooling rules to the inputs present at this rising edge.
  task automatic model_update();
    logic [DW-1:0] smp;
    longint        acc;
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        e_ov[s] = '0;
        for (int k = 0; k < LANES; k++) begin
          m_cnt[s][k] = 0;
          e_od[s][k]  = '0;
        end
      end else if (if_u.pass) begin
        e_ov[s] = if_u.in_valid;
        for (int k = 0; k < LANES; k++) begin
          m_cnt[s][k] = 0;
          e_od[s][k]  = if_u.in_data[k*DW +: DW];
        end
      end else begin
        e_ov[s] = '0;
        for (int k = 0; k < LANES; k++) begin
          if (if_u.clear) begin
            m_cnt[s][k] = 0;
          end else if (if_u.in_valid[k]) begin
            if (m_cnt[s][k] == 0) m_mode[s][k] = if_u.mode;
            smp = if_u.in_data[k*DW +: DW];
            m_smp[s][k][m_cnt[s][k]] = to_val(smp, s);
            m_cnt[s][k]++;
            if (m_cnt[s][k] == WIN) begin
              if (AVG_EN && m_mode[s][k]) begin
                acc = 0;
                for (int i = 0; i < WIN; i++) acc += m_smp[s][k][i];
                acc = acc >>> LOGW;
              end else begin
                acc = m_smp[s][k][0];
                for (int i = 1; i < WIN; i++) if (m_smp[s][k][i] > acc) acc = m_smp[s][k][i];
              end
              e_ov[s][k]  = 1'b1;
              e_od[s][k]  = acc[DW-1:0];
              m_cnt[s][k] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic model_check();
    logic [LANES*DW-1:0] pd;
    logic [LANES-1:0]    pb;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < LANES; k++) begin
        pd[k*DW +: DW] = e_od[s][k];
        pb[k]          = (m_cnt[s][k] != 0);
      end
      if (s == 0) begin
        cmp("model_u.out_valid", 64'(if_u.out_valid), 64'(e_ov[s]));
        cmp("model_u.out_data",  64'(if_u.out_data),  64'(pd));
        cmp("model_u.busy",      64'(if_u.busy),      64'(pb));
      end else begin
        cmp("model_s.out_valid", 64'(if_s.out_valid), 64'(e_ov[s]));
        cmp("model_s.out_data",  64'(if_s.out_data),  64'(pd));
        cmp("model_s.busy",      64'(if_s.busy),      64'(pb));
      end
    end
  endtask

  // One clock: model advances on the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    bit            rst, ps, cl;
    logic [1:0]    iv;
    logic [DW-1:0] d0, d1;
    logic [1:0]    eov, ebusy;
    logic [DW-1:0] ed0, ed1;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, input bit ps, input bit cl, input logic [1:0] iv,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] eov,
                     input logic [1:0] ebusy, input logic [DW-1:0] ed0, input logic [DW-1:0] ed1);
    vec_t v;
    v.rst = rst; v.ps = ps; v.cl = cl; v.iv = iv; v.d0 = d0; v.d1 = d1;
    v.eov = eov; v.ebusy = ebusy; v.ed0 = ed0; v.ed1 = ed1;
    tbl.push_back(v);
  endtask

  initial begin
    // Expected values are for the unsigned instance after each row's clock edge.
    add(1, 0, 0, 2'b00, 16'd0,  16'd0, 2'b00, 2'b00, 16'd0, 16'd0);      // reset
    add(0, 0, 0, 2'b01, 16'd3,  16'd0, 2'b00, 2'b01, 16'd0, 16'd0);      // 3,9,2,7 -> 9
    add(0, 0, 0, 2'b01, 16'd9,  16'd0, 2'b00, 2'b01, 16'd0, 16'd0);
    add(0, 0, 0, 2'b01, 16'd2,  16'd0, 2'b00, 2'b01, 16'd0, 16'd0);
    add(0, 0, 0, 2'b01, 16'd7,  16'd0, 2'b01, 2'b00, 16'd9, 16'd0);
    add(0, 0, 0, 2'b01, 16'd1,  16'd0, 2'b00, 2'b01, 16'd9, 16'd0);      // back-to-back 1..4
    add(0, 0, 0, 2'b01, 16'd2,  16'd0, 2'b00, 2'b01, 16'd9, 16'd0);
    add(0, 0, 0, 2'b01, 16'd3,  16'd0, 2'b00, 2'b01, 16'd9, 16'd0);
    add(0, 0, 0, 2'b01, 16'd4,  16'd0, 2'b01, 2'b00, 16'd4, 16'd0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 2'b01, 16'd8, 16'd0, 2'b00, 2'b01, 16'd4, 16'd0);
    add(0, 0, 0, 2'b01, 16'd8,  16'd0, 2'b01, 2'b00, 16'd8, 16'd0);
    add(0, 0, 0, 2'b01, 16'd6,  16'd0, 2'b00, 2'b01, 16'd8, 16'd0);      // aborted by reset
    add(0, 0, 0, 2'b01, 16'd6,  16'd0, 2'b00, 2'b01, 16'd8, 16'd0);
    add(1, 0, 0, 2'b01, 16'd9,  16'd0, 2'b00, 2'b00, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 2'b01, 16'd5, 16'd0, 2'b00, 2'b01, 16'd0, 16'd0);
    add(0, 0, 0, 2'b01, 16'd5,  16'd0, 2'b01, 2'b00, 16'd5, 16'd0);
    add(0, 1, 0, 2'b11, 16'h1234, 16'hABCD, 2'b11, 2'b00, 16'h1234, 16'hABCD);  // bypass
    add(0, 0, 0, 2'b01, 16'd100, 16'd0, 2'b00, 2'b01, 16'h1234, 16'hABCD);       // then clear
    add(0, 0, 0, 2'b01, 16'd200, 16'd0, 2'b00, 2'b01, 16'h1234, 16'hABCD);
    add(0, 0, 1, 2'b01, 16'd300, 16'd0, 2'b00, 2'b00, 16'h1234, 16'hABCD);
    add(0, 0, 0, 2'b01, 16'd1,  16'd0, 2'b00, 2'b01, 16'h1234, 16'hABCD);
    add(0, 0, 0, 2'b01, 16'd2,  16'd0, 2'b00, 2'b01, 16'h1234, 16'hABCD);
    add(0, 0, 0, 2'b01, 16'd3,  16'd0, 2'b00, 2'b01, 16'h1234, 16'hABCD);
    add(0, 0, 0, 2'b01, 16'd4,  16'd0, 2'b01, 2'b00, 16'd4, 16'hABCD);
    add(0, 0, 0, 2'b01, 16'd50, 16'd0, 2'b00, 2'b01, 16'd4, 16'hABCD);          // bypass mid-window
    add(0, 1, 0, 2'b00, 16'd77, 16'd88, 2'b00, 2'b00, 16'd77, 16'd88);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 2'b01, 16'd10, 16'd0, 2'b00, 2'b01, 16'd77, 16'd88);
    add(0, 0, 0, 2'b01, 16'd10, 16'd0, 2'b01, 2'b00, 16'd10, 16'd88);
    add(1, 1, 0, 2'b11, 16'd5,  16'd5, 2'b00, 2'b00, 16'd0, 16'd0);      // reset beats pass

    drive(1, 0, 0, 0, 2'b00, '0, '0);
    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ps, tbl[i].cl, 1'b0, tbl[i].iv, tbl[i].d0, tbl[i].d1);
      step();
      cmp($sformatf("vec%0d.out_valid", i), 64'(if_u.out_valid), 64'(tbl[i].eov));
      cmp($sformatf("vec%0d.busy", i), 64'(if_u.busy), 64'(tbl[i].ebusy));
      cmp($sformatf("vec%0d.data0", i), 64'(if_u.out_data[15:0]), 64'(tbl[i].ed0));
      cmp($sformatf("vec%0d.data1", i), 64'(if_u.out_data[31:16]), 64'(tbl[i].ed1));
    end

    // Mode toggled after the first sample is ignored: window stays max.
    drive(0, 0, 0, 0, 2'b01, 16'd10, 16'd0); step();
    drive(0, 0, 0, 1, 2'b01, 16'd20, 16'd0); step();
    drive(0, 0, 0, 1, 2'b01, 16'd30, 16'd0); step();
    drive(0, 0, 0, 1, 2'b01, 16'd40, 16'd0); step();
    cmp("latched_mode.valid", 64'(if_u.out_valid), 64'(2'b01));
    cmp("latched_mode.data", 64'(if_u.out_data[15:0]), 64'd40);
    // Same window with mode high from the start: average when enabled.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, 2'b01, DW'(10 * i), 16'd0);
      step();
    end
    cmp("avg_window.data", 64'(if_u.out_data[15:0]), AVG_EN ? 64'd25 : 64'd40);

    // Signed lane 1: -1,-2,-3,-4 averages to -3 (floor of -2.5); max gives -1.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, 2'b10, 16'd0, DW'(-i));
      step();
    end
    cmp("signed_avg.valid", 64'(if_s.out_valid), 64'(2'b10));
    cmp("signed_avg.data", 64'(if_s.out_data[31:16]), AVG_EN ? 64'hFFFD : 64'hFFFF);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
            1'($urandom_range(0, 1)), 2'($urandom), ($urandom_range(0, 3) == 0) ?
            DW'($urandom_range(0, 7)) : DW'($urandom), DW'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
